// File: rtl/pixel_stream_tx.sv
// Pixel stream transmitter: paces upstream pixel words into row/frame
// beats for the filter, with horizontal blanking and tail-lane masking.
module pixel_stream_tx #(
   parameter int DWIDTH = 10,
   parameter int PIXCNT = 8,
   parameter int ROWS   = 2048,
   parameter int COLS   = 2448,
   parameter int HBLANK = 4
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic                       start,
   input  logic [$clog2(ROWS)-1:0]    rowSize,
   input  logic [$clog2(COLS)-1:0]    colSize,
   input  logic [DWIDTH*PIXCNT-1:0]   s_data,
   input  logic                       s_vld,
   output logic                       s_rdy,
   output logic                       new_frame,
   output logic [DWIDTH*PIXCNT-1:0]   data_out,
   output logic                       data_vld,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       underrun
);

   localparam int RW  = $clog2(ROWS);
   localparam int CW  = $clog2(COLS);
   localparam int CW1 = CW + 1;
   localparam int LW  = $clog2(PIXCNT + 1);
   localparam int HW  = (HBLANK > 1) ? $clog2(HBLANK) : 1;
   localparam int BW  = DWIDTH * PIXCNT;

   typedef enum logic [2:0] {
      IDLE, SOF, LINE, HBLK, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] rows_q, rows_d;
   logic [CW:0]   bpr_q, bpr_d;
   logic [LW-1:0] last_lanes_q, last_lanes_d;
   logic [CW:0]   beat_cnt_q, beat_cnt_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [HW-1:0] hblk_cnt_q, hblk_cnt_d;
   logic          s_rdy_q, s_rdy_d;
   logic          new_frame_q, new_frame_d;
   logic [BW-1:0] data_out_q, data_out_d;
   logic          data_vld_q, data_vld_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;
   logic          underrun_q, underrun_d;

   logic          hs;
   logic          last_beat;
   logic          last_row;
   logic [CW:0]   cols_ext;
   logic [CW:0]   bpr_calc;
   logic [CW:0]   last_calc;
   logic [BW-1:0] beat_data;

   assign hs        = s_rdy_q && s_vld;
   assign last_beat = (beat_cnt_q == bpr_q - CW1'(1));
   assign last_row  = (row_cnt_q == rows_q - RW'(1));

   always_comb begin
      cols_ext  = {1'b0, colSize};
      bpr_calc  = (cols_ext + CW1'(PIXCNT - 1)) / CW1'(PIXCNT);
      last_calc = cols_ext - (bpr_calc - CW1'(1)) * CW1'(PIXCNT);
   end

   // Lanes past the end of the row on the final beat carry no pixels.
   always_comb begin
      beat_data = s_data;
      for (int i = 0; i < PIXCNT; i++) begin
         if (last_beat && i >= int'(last_lanes_q))
            beat_data[i*DWIDTH +: DWIDTH] = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      rows_d       = rows_q;
      bpr_d        = bpr_q;
      last_lanes_d = last_lanes_q;
      beat_cnt_d   = beat_cnt_q;
      row_cnt_d    = row_cnt_q;
      hblk_cnt_d   = hblk_cnt_q;
      s_rdy_d      = s_rdy_q;
      new_frame_d  = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      underrun_d   = underrun_q;
      data_vld_d   = hs;
      data_out_d   = hs ? beat_data : data_out_q;

      unique case (state_q)
         IDLE: begin
            busy_d  = 1'b0;
            s_rdy_d = 1'b0;
            if (start) begin
               busy_d = 1'b1;
               if (rowSize != '0 && colSize != '0) begin
                  rows_d       = rowSize;
                  bpr_d        = bpr_calc;
                  last_lanes_d = LW'(last_calc);
                  underrun_d   = 1'b0;
                  new_frame_d  = 1'b1;
                  state_d      = SOF;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SOF: begin
            beat_cnt_d = '0;
            row_cnt_d  = '0;
            s_rdy_d    = 1'b1;
            state_d    = LINE;
         end
         LINE: begin
            if (beat_cnt_q != '0 && !s_vld)
               underrun_d = 1'b1;
            if (hs) begin
               if (last_beat) begin
                  beat_cnt_d = '0;
                  if (last_row) begin
                     s_rdy_d      = 1'b0;
                     frame_done_d = 1'b1;
                     state_d      = DONE;
                  end else begin
                     row_cnt_d = row_cnt_q + RW'(1);
                     if (HBLANK > 0) begin
                        s_rdy_d    = 1'b0;
                        hblk_cnt_d = HW'(HBLANK > 0 ? HBLANK - 1 : 0);
                        state_d    = HBLK;
                     end
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + CW1'(1);
               end
            end
         end
         HBLK: begin
            if (hblk_cnt_q == '0) begin
               s_rdy_d = 1'b1;
               state_d = LINE;
            end else begin
               hblk_cnt_d = hblk_cnt_q - HW'(1);
            end
         end
         DONE: begin
            // An empty frame arrives here without a pulse; emit it now.
            if (frame_done_q) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         rows_q       <= '0;
         bpr_q        <= '0;
         last_lanes_q <= '0;
         beat_cnt_q   <= '0;
         row_cnt_q    <= '0;
         hblk_cnt_q   <= '0;
         s_rdy_q      <= 1'b0;
         new_frame_q  <= 1'b0;
         data_out_q   <= '0;
         data_vld_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rows_q       <= rows_d;
         bpr_q        <= bpr_d;
         last_lanes_q <= last_lanes_d;
         beat_cnt_q   <= beat_cnt_d;
         row_cnt_q    <= row_cnt_d;
         hblk_cnt_q   <= hblk_cnt_d;
         s_rdy_q      <= s_rdy_d;
         new_frame_q  <= new_frame_d;
         data_out_q   <= data_out_d;
         data_vld_q   <= data_vld_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign s_rdy      = s_rdy_q;
   assign new_frame  = new_frame_q;
   assign data_out   = data_out_q;
   assign data_vld   = data_vld_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: per-cycle output masks captured
// after each start and compared with hand-derived timelines.
module tb_pixel_stream_tx;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [10:0]   rowSize;
   logic [11:0]   colSize;
   logic [79:0]   s_data;
   logic          s_vld;
   logic          s_rdy;
   logic          new_frame;
   logic [79:0]   data_out;
   logic          data_vld;
   logic          busy;
   logic          frame_done;
   logic          underrun;

   int n_chk;
   int n_err;

   logic [31:0] m_vld, m_done, m_nf, m_rdy, m_busy, m_urun;
   logic [79:0] dout [32];
   logic [31:0] vld_sched;
   logic [31:0] start_sched;
   logic        ones;
   logic [10:0] alt_r;
   logic [11:0] alt_c;

   pixel_stream_tx dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .start      (start),
      .rowSize    (rowSize),
      .colSize    (colSize),
      .s_data     (s_data),
      .s_vld      (s_vld),
      .s_rdy      (s_rdy),
      .new_frame  (new_frame),
      .data_out   (data_out),
      .data_vld   (data_vld),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [79:0] got,
                        input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] pat(input int k);
      logic [79:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         v[i*10 +: 10] = 10'(k * 16 + i + 1);
      return v;
   endfunction

   function automatic logic [79:0] word(input int k);
      return ones ? {80{1'b1}} : pat(k);
   endfunction

   // Called at a negedge: this cycle is T, start sampled at its end.
   task automatic launch(input logic [10:0] r, input logic [11:0] c);
      start   = 1'b1;
      rowSize = r;
      colSize = c;
      s_vld   = vld_sched[0];
      s_data  = word(0);
   endtask

   task automatic run(input int n);
      m_vld  = '0;
      m_done = '0;
      m_nf   = '0;
      m_rdy  = '0;
      m_busy = '0;
      m_urun = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         m_vld[k]  = data_vld;
         m_done[k] = frame_done;
         m_nf[k]   = new_frame;
         m_rdy[k]  = s_rdy;
         m_busy[k] = busy;
         m_urun[k] = underrun;
         dout[k]   = data_out;
         start     = start_sched[k];
         if (start_sched[k]) begin
            rowSize = alt_r;
            colSize = alt_c;
         end
         s_vld  = vld_sched[k];
         s_data = word(k);
      end
   endtask

   initial begin
      n_chk       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      rowSize     = '0;
      colSize     = '0;
      s_data      = '0;
      s_vld       = 1'b0;
      ones        = 1'b0;
      vld_sched   = '1;
      start_sched = '0;
      alt_r       = '0;
      alt_c       = '0;

      repeat (3) @(negedge clk);
      check("reset_ctl", 80'({s_rdy, new_frame, data_vld, busy,
                              frame_done, underrun}), 80'h0);
      check("reset_data", data_out, 80'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 80'({busy, s_rdy}), 80'h0);

      // two rows of 16 pixels with blanking between them
      launch(11'd2, 12'd16);
      run(13);
      check("r2c16_nf", 80'(m_nf), 80'h2);
      check("r2c16_rdy", 80'(m_rdy), 80'h30C);
      check("r2c16_vld", 80'(m_vld), 80'h618);
      check("r2c16_done", 80'(m_done), 80'h400);
      check("r2c16_busy", 80'(m_busy), 80'h7FE);
      check("r2c16_d0", dout[3], pat(2));
      check("r2c16_hold", dout[7], pat(3));
      check("r2c16_dlast", dout[10], pat(9));

      // partial last beat: lanes 4..7 cleared
      ones = 1'b1;
      launch(11'd1, 12'd12);
      run(6);
      ones = 1'b0;
      check("c12_beat1", dout[3], {80{1'b1}});
      check("c12_beat2", dout[4], 80'h0000000000FFFFFFFFFF);
      check("c12_vld", 80'(m_vld), 80'h18);
      check("c12_done", 80'(m_done), 80'h10);

      // empty frames
      launch(11'd0, 12'd16);
      run(5);
      check("r0_done", 80'(m_done), 80'h4);
      check("r0_quiet", 80'(m_nf | m_rdy | m_vld), 80'h0);
      check("r0_busy", 80'(m_busy), 80'h6);
      launch(11'd2, 12'd0);
      run(5);
      check("c0_done", 80'(m_done), 80'h4);
      check("c0_quiet", 80'(m_nf | m_rdy | m_vld), 80'h0);

      // upstream starves for 3 cycles after 3 beats of a 6-beat row
      vld_sched = ~32'h000000E0;
      launch(11'd1, 12'd48);
      run(14);
      vld_sched = '1;
      check("urun_vld", 80'(m_vld), 80'hE38);
      check("urun_done", 80'(m_done), 80'h800);
      check("urun_flag", 80'(m_urun), 80'h7FC0);
      check("urun_resume", dout[9], pat(8));
      check("urun_busy", 80'(m_busy), 80'hFFE);
      launch(11'd1, 12'd8);
      run(5);
      check("urun_clear", 80'(m_urun), 80'h0);
      check("c8_done", 80'(m_done), 80'h8);

      // asynchronous reset in the middle of a row
      launch(11'd2, 12'd32);
      run(3);
      check("mid_vld", 80'(m_vld[3]), 80'h1);
      rst_n = 1'b0;
      #1;
      check("arst_ctl", 80'({s_rdy, new_frame, data_vld, busy,
                             frame_done, underrun}), 80'h0);
      check("arst_data", data_out, 80'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(11'd1, 12'd8);
      run(5);
      check("post_nf", 80'(m_nf), 80'h2);
      check("post_vld", 80'(m_vld), 80'h8);
      check("post_done", 80'(m_done), 80'h8);

      // start during LINE with different sizes is ignored
      start_sched = 32'h4;
      alt_r       = 11'd2;
      alt_c       = 12'd64;
      launch(11'd1, 12'd16);
      run(7);
      start_sched = '0;
      check("ign_nf", 80'(m_nf), 80'h2);
      check("ign_vld", 80'(m_vld), 80'h18);
      check("ign_done", 80'(m_done), 80'h10);
      check("ign_busy", 80'(m_busy), 80'h1E);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
